systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
- Sequencer for the 8x8 weight-stationary systolic array tile.
- Drives the tile's enable, input_write, output_write, output_read and row_ptr controls.
- Runs one matrix pass: load B/A rows, compute/capture, drain results through the reverse skew buffer.
- Exposes a start/done job interface plus valid/ready row streams to the host-side buffers.

Parameters:
- ARRAY_SIZE, 8: rows/columns of the tile; row_ptr width is $clog2(ARRAY_SIZE).
- RUN_CYCLES, 24: cycles spent in RUN after the last input row is written.
- CAPTURE_START, 9: RUN cycle index at which arr_output_write first asserts.
- Constraint: CAPTURE_START+ARRAY_SIZE <= RUN_CYCLES. Enforced by an elaboration-time assertion.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request pulse; sampled in IDLE only.
- abort  in  1  synchronous abort; forces IDLE from any state.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse at job completion.
- in_valid  in  1  host presents one B row and one A row.
- in_ready  out  1  controller accepts a row this cycle.
- out_ready  in  1  host can accept a result row.
- res_valid  out  1  result row on the tile c_out is valid.
- err  out  1  sticky protocol error; cleared by start or reset.
- arr_enable  out  1  tile enable.
- arr_input_write  out  1  tile input_write.
- arr_output_write  out  1  tile output_write.
- arr_output_read  out  1  tile output_read.
- arr_row_ptr  out  $clog2(ARRAY_SIZE)  tile row_ptr.
- arr_read_valid  in  1  tile read_valid.

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters 0; busy, done, err, res_valid and every arr_* output = 0.
- States: IDLE, LOAD, RUN, READ, FIN.
- IDLE:
  - arr_enable=0, in_ready=0.
  - start=1 -> LOAD next cycle; row counter cleared; err cleared.
- LOAD:
  - arr_enable=1, in_ready=1.
  - arr_input_write = in_valid (combinational); arr_row_ptr = row counter.
  - Each accepted row (in_valid&in_ready) increments the counter.
  - Acceptance at counter=ARRAY_SIZE-1 -> RUN; cycle counter cleared.
  - Gaps (in_valid=0) stall without timeout.
- RUN:
  - arr_enable=1, in_ready=0, arr_input_write=0.
  - Cycle counter c counts 0..RUN_CYCLES-1.
  - arr_output_write=1 iff CAPTURE_START <= c < CAPTURE_START+ARRAY_SIZE.
  - c=RUN_CYCLES-1 -> READ; issued and received counters cleared.
- READ:
  - arr_enable=1.
  - arr_output_read = out_ready & (issued < ARRAY_SIZE); each assertion increments issued.
  - res_valid = arr_read_valid (combinational pass-through); each arr_read_valid increments received.
  - received reaches ARRAY_SIZE -> FIN.
  - out_ready low pauses read issue only; data already in flight is still counted.
- FIN: done=1 for exactly one cycle, arr_enable=0, then IDLE. busy=1 in FIN, 0 in the following IDLE cycle.
- start outside IDLE is ignored, with no effect on state or counters.
- in_valid outside LOAD is ignored; in_ready=0.
- arr_read_valid=1 outside READ, or after received=ARRAY_SIZE, sets err. err stays 1 until the next accepted start or reset. res_valid stays 0 in that case.
- abort=1:
  - Next cycle state=IDLE; counters cleared; all arr_* outputs 0; no done pulse.
  - abort has priority over every other transition, including start in IDLE.
- Simultaneous start and abort in IDLE: remain in IDLE.
- Reset mid-job: immediate return to IDLE values; the tile is reset by the same rst.
- Latency, with no stalls: start -> first arr_input_write = 1 cycle. LOAD = ARRAY_SIZE cycles; RUN = RUN_CYCLES cycles.
- Widths: counters sized $clog2(max(RUN_CYCLES, ARRAY_SIZE+1)); no arithmetic overflow is permitted.

Test Plan:
- Nominal job:
  - Stimulus: start pulse; in_valid held 1; out_ready held 1; tile model returns read_valid one cycle after each output_read.
  - Required: arr_input_write high 8 cycles with row_ptr 0..7; arr_output_write high at RUN cycles 9..16; 8 arr_output_read pulses; done pulses once.
  - Timing: done must not assert before cycle 1+8+24+8 after start.
- Input gaps: in_valid pattern 1,0,1,1,0,0,1,1,1,1,1.
  - Required: exactly 8 writes; row_ptr advances only on accepted cycles; RUN entered the cycle after the 8th acceptance.
- Output backpressure: out_ready toggled 1,0,0,1 repeating.
  - Required: arr_output_read only when out_ready=1; total 8; res_valid count=8; then done.
- Abort: abort asserted at RUN cycle 5.
  - Required: next cycle busy=0, all arr_*=0, no done.
  - Follow-up: a new start runs a full nominal job correctly.
- Protocol error and ignored inputs:
  - Inject arr_read_valid=1 in IDLE -> err=1 and res_valid=0; start then clears err.
  - start during LOAD -> no change to row_ptr sequence.
- Async reset: drop rst mid-READ, off clock edge.
  - Required: outputs go to 0 immediately; state=IDLE after release; the next start behaves nominally.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: job sequencer for a weight-stationary systolic tile.
// One job walks LOAD (ARRAY_SIZE B/A rows) -> RUN (RUN_CYCLES compute/capture)
// -> READ (drain ARRAY_SIZE result rows) -> FIN (one-cycle done) -> IDLE.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   start, abort        job request (IDLE only) / synchronous abort to IDLE
//   busy, done, err     status: not-IDLE, completion pulse, sticky protocol error
//   in_valid, in_ready  host row input handshake (LOAD only)
//   out_ready, res_valid host result handshake (READ only)
//   arr_*               tile controls; arr_read_valid is the tile's read strobe
module systolic_seq_ctrl #(
  parameter int ARRAY_SIZE    = 8,
  parameter int RUN_CYCLES    = 24,
  parameter int CAPTURE_START = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          out_ready,
  output logic                          res_valid,
  output logic                          err,
  output logic                          arr_enable,
  output logic                          arr_input_write,
  output logic                          arr_output_write,
  output logic                          arr_output_read,
  output logic [$clog2(ARRAY_SIZE)-1:0] arr_row_ptr,
  input  logic                          arr_read_valid
);

  localparam int PW   = $clog2(ARRAY_SIZE);
  localparam int MAXC = (RUN_CYCLES > ARRAY_SIZE + 1) ? RUN_CYCLES : ARRAY_SIZE + 1;
  localparam int CW   = $clog2(MAXC);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [CW-1:0] LAST_ROW = CW'(ARRAY_SIZE - 1);
  localparam logic [CW-1:0] ROWS     = CW'(ARRAY_SIZE);
  localparam logic [CW-1:0] LAST_CYC = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] CAP_LO   = CW'(CAPTURE_START);
  // inclusive upper bound keeps the constant below RUN_CYCLES so it always fits CW
  localparam logic [CW-1:0] CAP_HI   = CW'(CAPTURE_START + ARRAY_SIZE - 1);

  generate
    if (CAPTURE_START + ARRAY_SIZE > RUN_CYCLES) begin : g_bad_cfg
      $error("systolic_seq_ctrl: CAPTURE_START+ARRAY_SIZE exceeds RUN_CYCLES");
    end
  endgenerate

  logic [2:0]    state;
  logic [CW-1:0] row_cnt, cyc_cnt, issued, received;

  logic st_load, st_run, st_read;
  logic accept, rd_issue, rd_take, start_ok;

  assign st_load  = (state == S_LOAD);
  assign st_run   = (state == S_RUN);
  assign st_read  = (state == S_READ);

  assign accept   = st_load & in_valid;
  assign rd_issue = st_read & out_ready & (issued != ROWS);
  // read_valid is only legitimate in READ while results are still owed
  assign rd_take  = st_read & arr_read_valid & (received != ROWS);
  assign start_ok = (state == S_IDLE) & start & ~abort;

  assign busy             = (state != S_IDLE);
  assign done             = (state == S_FIN);
  assign in_ready         = st_load;
  assign arr_enable       = st_load | st_run | st_read;
  assign arr_input_write  = accept;
  assign arr_row_ptr      = st_load ? row_cnt[PW-1:0] : '0;
  assign arr_output_write = st_run & (cyc_cnt >= CAP_LO) & (cyc_cnt <= CAP_HI);
  assign arr_output_read  = rd_issue;
  assign res_valid        = rd_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      row_cnt  <= '0;
      cyc_cnt  <= '0;
      issued   <= '0;
      received <= '0;
    end else if (abort) begin
      state    <= S_IDLE;
      row_cnt  <= '0;
      cyc_cnt  <= '0;
      issued   <= '0;
      received <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state   <= S_LOAD;
          row_cnt <= '0;
        end
        S_LOAD: if (accept) begin
          if (row_cnt == LAST_ROW) begin
            state   <= S_RUN;
            row_cnt <= '0;
            cyc_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (cyc_cnt == LAST_CYC) begin
            state    <= S_READ;
            cyc_cnt  <= '0;
            issued   <= '0;
            received <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_READ: begin
          if (rd_issue) issued <= issued + 1'b1;
          if (rd_take) begin
            received <= received + 1'b1;
            if (received == LAST_ROW) state <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // a stray read_valid in the same cycle as an accepted start still flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else if (arr_read_valid & ~rd_take) err <= 1'b1;
    else if (start_ok) err <= 1'b0;
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: directed jobs plus $urandom jobs, every output
// compared each cycle against a job-progress model (rows taken, RUN time,
// reads issued/returned) kept in plain counters.
module tb_systolic_seq_ctrl;
  logic       clk = 1'b0, rst = 1'b0;
  logic       start = 0, abort = 0, in_valid = 0, out_ready = 0, arr_read_valid = 0;
  logic       busy, done, in_ready, res_valid, err;
  logic       arr_enable, arr_input_write, arr_output_write, arr_output_read;
  logic [2:0] arr_row_ptr;

  systolic_seq_ctrl #(.ARRAY_SIZE(8), .RUN_CYCLES(24), .CAPTURE_START(9)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .res_valid(res_valid), .err(err), .arr_enable(arr_enable),
    .arr_input_write(arr_input_write), .arr_output_write(arr_output_write),
    .arr_output_read(arr_output_read), .arr_row_ptr(arr_row_ptr),
    .arr_read_valid(arr_read_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // reference job state
  bit m_active, m_fin, m_err;
  int m_rows, m_run_t, m_issued, m_got;
  // tile model: read_valid one cycle after output_read
  bit tile_pend;
  // per-job observation counters
  int g_t, j_wr, j_rd, j_rv, j_done, j_bad, done_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_fin = 0; m_err = 0;
    m_rows = 0; m_run_t = 0; m_issued = 0; m_got = 0;
    tile_pend = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_arr"}, {arr_enable, arr_input_write, arr_output_write,
                        arr_output_read, arr_row_ptr}, 0);
  endtask

  // One cycle: called at a negedge, applies inputs, checks, advances model,
  // returns at the following negedge.
  task automatic tick(input bit iv, input bit orr, input bit st, input bit ab, input bit inj);
    bit loading, running, reading, e_rd, rv, tile_nxt;
    rv = tile_pend | inj;
    in_valid = iv; out_ready = orr; start = st; abort = ab; arr_read_valid = rv;
    #1;
    loading = m_active && m_rows < 8;
    running = m_active && m_rows == 8 && m_run_t < 24;
    reading = m_active && m_run_t == 24;
    e_rd    = reading && orr && m_issued < 8;
    chk("busy", busy, m_active || m_fin);
    chk("done", done, m_fin);
    chk("in_ready", in_ready, loading);
    chk("arr_enable", arr_enable, m_active);
    chk("input_write", arr_input_write, loading && iv);
    chk("row_ptr", arr_row_ptr, loading ? m_rows : 0);
    chk("output_write", arr_output_write, running && m_run_t >= 9 && m_run_t < 17);
    chk("output_read", arr_output_read, e_rd);
    chk("res_valid", res_valid, reading && rv);
    chk("err", err, m_err);
    j_wr += int'(arr_input_write);
    j_rd += int'(arr_output_read);
    j_rv += int'(res_valid);
    if (done) begin j_done++; done_at = g_t; end
    if (arr_output_read && !orr) j_bad++;
    tile_nxt = arr_output_read;
    // reference update
    if (!m_active && !m_fin && st && !ab) m_err = 0;
    if (rv && !reading) m_err = 1;
    if (ab) begin
      m_active = 0; m_fin = 0;
    end else if (m_fin) m_fin = 0;
    else if (!m_active) begin
      if (st) begin
        m_active = 1; m_rows = 0; m_run_t = 0; m_issued = 0; m_got = 0;
      end
    end else if (loading) begin
      if (iv) m_rows++;
    end else if (running) m_run_t++;
    else begin
      if (e_rd) m_issued++;
      if (rv) m_got++;
      if (m_got == 8) begin m_active = 0; m_fin = 1; end
    end
    @(posedge clk);
    tile_pend = tile_nxt;
    @(negedge clk);
    g_t++;
  endtask

  // ivm/orm: 0 = held 1, 1 = directed pattern, 2 = random
  task automatic run_job(input int ivm, input int orm, input int abort_at,
                         input bit st_in_load, input bit rst_in_read, input bit nominal);
    bit iv_pat [11] = '{1,0,1,1,0,0,1,1,1,1,1};
    bit or_pat [4]  = '{1,0,0,1};
    int ivp, orp, t0;
    bit stop, iv, orr, st, ab, inj, loading, running, reading;
    ivp = 0; orp = 0; stop = 0;
    j_wr = 0; j_rd = 0; j_rv = 0; j_done = 0; j_bad = 0; done_at = -1;
    t0 = g_t;
    tick(ivm == 2 ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t < 400 && !stop; t++) begin
      loading = m_active && m_rows < 8;
      running = m_active && m_rows == 8 && m_run_t < 24;
      reading = m_active && m_run_t == 24;
      case (ivm)
        0:       iv = 1'b1;
        1:       begin iv = loading ? iv_pat[ivp % 11] : 1'b0; if (loading) ivp++; end
        default: iv = 1'($urandom_range(0, 1));
      endcase
      case (orm)
        0:       orr = 1'b1;
        1:       begin orr = reading ? or_pat[orp % 4] : 1'b0; if (reading) orp++; end
        default: orr = 1'($urandom_range(0, 1));
      endcase
      st  = (st_in_load && loading) || (ivm == 2 && !loading && $urandom_range(0, 7) == 0 && m_active);
      ab  = (abort_at >= 0) && running && (m_run_t == abort_at);
      inj = (ivm == 2) && !reading && m_active && ($urandom_range(0, 31) == 0);
      tick(iv, orr, st, ab, inj);
      if (ab) begin
        chk("abort_busy", busy, 0);
        chk("abort_arr", {arr_enable, arr_input_write, arr_output_write,
                          arr_output_read, arr_row_ptr}, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_no_done", j_done, 0);
        stop = 1;
      end else if (rst_in_read && m_active && m_run_t == 24 && m_issued == 3) begin
        #3 rst = 1'b0;
        #1 chk_all_zero("async_rst");
        model_clear();
        arr_read_valid = 0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        g_t += 2;
        stop = 1;
      end else if (done_at >= 0) stop = 1;
    end
    if (!stop) chk("job_timeout", 0, 1);
    if (abort_at < 0 && !rst_in_read) begin
      chk("writes", j_wr, 8);
      chk("reads", j_rd, 8);
      chk("res_valid_cnt", j_rv, 8);
      chk("done_cnt", j_done, 1);
      chk("read_without_ready", j_bad, 0);
      chk("done_not_early", (done_at - t0) >= 41, 1);
      if (nominal) chk("done_latency", done_at - t0, 42);
    end
  endtask

  initial begin
    model_clear();
    g_t = 0;
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // stray read_valid in IDLE: sticky err, no res_valid
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_sticky", err, 1);
    // start together with abort stays in IDLE
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_abort_idle", busy, 0);

    run_job(0, 0, -1, 1'b0, 1'b0, 1'b1);   // nominal, also clears err
    chk("err_cleared", err, 0);
    run_job(1, 0, -1, 1'b1, 1'b0, 1'b0);   // input gaps + start during LOAD
    run_job(0, 1, -1, 1'b0, 1'b0, 1'b0);   // output backpressure
    run_job(0, 0, 5, 1'b0, 1'b0, 1'b0);    // abort at RUN cycle 5
    run_job(0, 0, -1, 1'b0, 1'b0, 1'b1);   // nominal after abort
    run_job(0, 0, -1, 1'b0, 1'b1, 1'b0);   // async reset mid-READ
    run_job(0, 0, -1, 1'b0, 1'b0, 1'b1);   // nominal after reset
    for (int k = 0; k < 6; k++) run_job(2, 2, -1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
